// File: rtl/mux_nx1_stream.sv
// N-to-1 stream multiplexer with one registered output stage.
// Grants by fixed select or round-robin from the last granted channel.
module mux_nx1_stream #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(1<<SEL_W)*WIDTH-1:0]   in_data,
  input  logic [(1<<SEL_W)-1:0]         in_valid,
  output logic [(1<<SEL_W)-1:0]         in_ready,
  input  logic                          mode,
  input  logic [SEL_W-1:0]              sel,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SEL_W-1:0]              out_ch
);

  localparam int N = 1 << SEL_W;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;

  logic             load_en;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W-1:0] idx;
  logic             xfer;

  assign load_en = !out_valid_q || out_ready;

  // Round-robin search starts one past the last grant and wraps.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    if (!mode) begin
      gnt     = sel;
      gnt_vld = in_valid[sel];
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = last_grant_q + SEL_W'(k);
        if (!gnt_vld && in_valid[idx]) begin
          gnt     = idx;
          gnt_vld = 1'b1;
        end
      end
    end
  end

  assign xfer = load_en && gnt_vld && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt] = 1'b1;
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      if (gnt_vld) begin
        out_data_d   = in_data[int'(gnt)*WIDTH +: WIDTH];
        out_valid_d  = 1'b1;
        out_ch_d     = gnt;
        last_grant_d = gnt;
      end else begin
        out_valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      last_grant_q <= SEL_W'(N - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Scoreboard bench for mux_nx1_stream: directed cases then random traffic
// against a queue-based reference model of the grant rules.
module tb_mux_nx1_stream;

  localparam int W  = 4;
  localparam int SW = 2;
  localparam int N  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_ch;

  mux_nx1_stream #(.WIDTH(W), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int           ch;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   m_valid;
  int   m_last;
  bit   m_after_rst;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, then predict in_ready and what this edge loads.
  task automatic step(bit r, bit md, int s, logic [N-1:0] v,
                      logic [N*W-1:0] d, bit ordy);
    int g;
    bit le;
    int exp_rdy;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mode = md; sel = SW'(s);
    in_valid = v; in_data = d; out_ready = ordy;
    #2;
    if (m_after_rst) begin
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_ch", int'(out_ch), 0);
      m_after_rst = 0;
    end
    if (r) begin
      chk("in_ready_in_rst", int'(in_ready), 0);
      q.delete();
      m_valid = 0;
      m_last = N - 1;
      m_after_rst = 1;
      return;
    end
    chk("out_valid", int'(out_valid), int'(m_valid));
    le = !m_valid || ordy;
    g = -1;
    if (!md) begin
      if (v[s]) g = s;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && v[(m_last + k) % N]) g = (m_last + k) % N;
      end
    end
    exp_rdy = (le && g >= 0) ? (1 << g) : 0;
    chk("in_ready", int'(in_ready), exp_rdy);
    if (le) begin
      if (g >= 0) begin
        e.d = d[g*W +: W];
        e.ch = g;
        q.push_back(e);
        m_valid = 1;
        m_last = g;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  // Monitor: the held word must match the queue head until it is accepted.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%0d required=none", out_data);
      end else begin
        chk("out_data", int'(out_data), int'(q[0].d));
        chk("out_ch", int'(out_ch), q[0].ch);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0;
    in_valid = '0; in_data = '0; out_ready = 1'b0;
    m_valid = 0; m_last = N - 1; m_after_rst = 0;

    step(1, 0, 0, 4'b0000, '0, 1);
    step(1, 0, 0, 4'b0000, '0, 1);

    // Fixed select picks channel 2 among all-valid inputs.
    step(0, 0, 2, 4'b1111, {4'd4, 4'd3, 4'd2, 4'd1}, 1);
    chk("sel2_in_ready", int'(in_ready), 4);
    step(0, 0, 2, 4'b0000, '0, 1);
    chk("sel2_out_data", int'(out_data), 3);
    chk("sel2_out_ch", int'(out_ch), 2);

    // Round-robin rotation from reset, no bubbles.
    step(1, 1, 0, 4'b0000, '0, 1);
    for (int k = 1; k <= 7; k++) begin
      step(0, 1, 0, 4'b1111, 16'h4321, 1);
      if (k >= 2) begin
        chk("rr_seq_ch", int'(out_ch), (k - 2) % N);
        chk("rr_seq_valid", int'(out_valid), 1);
      end
    end

    // Stall: held word stays put, nothing accepted.
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 4'b1111, 16'h9876, 0);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    step(0, 1, 0, 4'b1111, 16'h9876, 1);
    step(0, 1, 0, 4'b0000, 16'h0000, 1);

    // Fixed select on an idle channel: no grant, output drains.
    step(0, 0, 1, 4'b1101, 16'h5555, 1);
    chk("idle_sel_in_ready", int'(in_ready), 0);
    step(0, 0, 1, 4'b1101, 16'h5555, 1);
    chk("idle_sel_drained", int'(out_valid), 0);

    // Reset while holding 0xA; first RR grant after reset is channel 0.
    step(0, 0, 0, 4'b0001, 16'h000A, 0);
    step(1, 0, 0, 4'b0001, 16'h000A, 0);
    chk("pre_rst_data", int'(out_data), 10);
    step(0, 1, 0, 4'b1111, 16'h4321, 1);
    chk("post_rst_valid", int'(out_valid), 0);
    step(0, 1, 0, 4'b0000, 16'h0000, 1);
    chk("post_rst_first_ch", int'(out_ch), 0);

    // Single valid channel 3 gets every cycle.
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 4'b1000, {4'(k + 1), 12'h000}, 1);
      if (k >= 1) chk("single_ch3", int'(out_ch), 3);
    end

    // Random traffic with occasional resets and mode/sel changes.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom),
           int'($urandom_range(0, N - 1)), N'($urandom),
           (N*W)'($urandom), ($urandom_range(0, 3) != 0));
    end
    step(0, 1, 0, 4'b0000, '0, 1);
    step(0, 1, 0, 4'b0000, '0, 1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
